fetch_prefetch_buffer: RTL

//  Instruction-fetch front end that sits directly upstream of main_memory and drives its

---
 rtl/fetch_prefetch_buffer_if.sv | 23 ++
 rtl/fetch_prefetch_buffer.sv | 91 +++++++++
 2 files changed

// File: rtl/fetch_prefetch_buffer_if.sv
// fetch_prefetch_buffer_if: decode handshake, redirect and main_memory read port of the fetch unit
interface fetch_prefetch_buffer_if;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] mem_address;
  logic [1:0]  mem_access_size;
  logic        mem_read_not_write;
  logic        mem_enable;
  logic        mem_busy;
  logic [31:0] mem_data;
  modport master (
    input  redirect, redirect_pc, inst_ready, mem_busy, mem_data,
    output inst_out, inst_pc, inst_valid, mem_address, mem_access_size, mem_read_not_write, mem_enable
  );
  modport slave (
    output redirect, redirect_pc, inst_ready, mem_busy, mem_data,
    input  inst_out, inst_pc, inst_valid, mem_address, mem_access_size, mem_read_not_write, mem_enable
  );
endinterface

// File: rtl/fetch_prefetch_buffer.sv
// fetch_prefetch_buffer: burst instruction prefetcher feeding decode through a FIFO
module fetch_prefetch_buffer #(
  parameter logic [31:0] RESET_PC    = 32'h8002_0000,
  parameter int          FIFO_DEPTH  = 8,
  parameter int          BURST_WORDS = 4
) (
  input logic clk,
  input logic rst_n,
  fetch_prefetch_buffer_if.master bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int RW = BURST_WORDS > 1 ? $clog2(BURST_WORDS) : 1;
  localparam logic [RW-1:0] RX_LAST = RW'(BURST_WORDS - 1);
  localparam logic [AW:0] DEPTH = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] BW = (AW+1)'(BURST_WORDS);
  localparam logic [31:0] BURST_BYTES = 32'(BURST_WORDS * 4);
  typedef enum logic [1:0] {IDLE, ISSUE, RECV} state_t;
  state_t state, state_nx;
  logic [31:0] fetch_pc, burst_base, rx_pc;
  logic [RW-1:0] rx_cnt;
  logic discard, last, push, pop, valid, en;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count, free_after;
  logic [31:0] data_q [FIFO_DEPTH];
  logic [31:0] pc_q [FIFO_DEPTH];
  assign valid = count != '0;
  assign pop = valid && bus.inst_ready && !bus.redirect;
  assign last = state == RECV && rx_cnt == RX_LAST;
  assign push = state == RECV && !discard && !bus.redirect;
  assign rx_pc = burst_base + 32'({rx_cnt, 2'b00});
  assign free_after = DEPTH - count + (AW+1)'(pop);
  assign bus.inst_valid = valid;
  assign bus.inst_out = data_q[rd_ptr];
  assign bus.inst_pc = pc_q[rd_ptr];
  assign bus.mem_enable = en;
  assign bus.mem_address = state == RECV ? burst_base : fetch_pc;
  assign bus.mem_access_size = BURST_WORDS == 16 ? 2'd3 : BURST_WORDS == 8 ? 2'd2 : BURST_WORDS == 4 ? 2'd1 : 2'd0;
  assign bus.mem_read_not_write = 1'b1;
  // burst sequencer state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // next state; issue only with a whole burst of FIFO space free so pushes can never overflow
  always_comb begin
    state_nx = state;
    en = 1'b0;
    state_nx = state == IDLE ? (!bus.redirect && !bus.mem_busy && free_after >= BW ? ISSUE : IDLE)
             : state == ISSUE ? RECV
             : state == RECV ? (last ? IDLE : RECV)
             : IDLE;
    en = state == ISSUE || (state == RECV && rx_cnt != RX_LAST);
  end
  // fetch PC, burst bookkeeping and discard of bursts overtaken by a redirect
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
      burst_base <= RESET_PC;
      rx_cnt <= '0;
      discard <= 1'b0;
    end else begin
      if (state == ISSUE) begin
        burst_base <= fetch_pc;
        rx_cnt <= '0;
      end
      if (state == RECV) rx_cnt <= rx_cnt + RW'(1);
      if (bus.redirect) fetch_pc <= bus.redirect_pc & 32'hFFFF_FFFC;
      else if (last && !discard) fetch_pc <= burst_base + BURST_BYTES;
      discard <= last ? 1'b0 : (bus.redirect && state != IDLE) ? 1'b1 : discard;
    end
  // FIFO pointers and occupancy; a redirect empties it and overrides this cycle's pop
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else if (bus.redirect) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  // FIFO storage of each captured word with its address
  always_ff @(posedge clk)
    if (push) begin
      data_q[wr_ptr] <= bus.mem_data;
      pc_q[wr_ptr] <= rx_pc;
    end
endmodule
